// File: rtl/baud_gen_frac_pkg.sv
// Shared UART definitions: oversampling and divisor defaults plus a width helper.
// Also used by the UART TX/RX blocks.
package baud_gen_frac_pkg;

    localparam int UART_OSR     = 16;
    localparam int UART_DEF_INT = 16;

    // Counter width for a modulus; never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/baud_gen_frac_mod_counter.sv
// Generic modulo counter: counts enabled cycles from 0 to MODULUS-1 and flags the wrap.
module mod_counter
    import baud_gen_frac_pkg::*;
#(
    parameter int MODULUS = 16,
    parameter int W       = clog2_min1(MODULUS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    logic [W-1:0] count_reg;

    assign count = count_reg;
    assign wrap  = en & ~clr & (count_reg == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample tick every div_int + div_frac/2^FRAC_W cycles on
// average, with mid-bit and end-of-bit pulses derived from the oversample count.
module baud_gen_frac
    import baud_gen_frac_pkg::*;
#(
    parameter int INT_W   = 16,
    parameter int FRAC_W  = 4,
    parameter int OSR     = UART_OSR,
    parameter int DEF_INT = UART_DEF_INT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              sync,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              div_err
);

    localparam int OSC_W = clog2_min1(OSR);

    logic [INT_W-1:0]  cnt_reg;
    logic [INT_W-1:0]  sh_int_reg;
    logic [FRAC_W-1:0] acc_reg;
    logic [FRAC_W-1:0] sh_frac_reg;
    logic              ext_reg;

    logic [INT_W:0]    eff;
    logic [INT_W:0]    period_last;
    logic [FRAC_W:0]   acc_sum;
    logic [OSC_W-1:0]  osc;
    logic              osc_wrap;
    logic              restart;

    // Divisors below 2 cannot produce a one-cycle tick pulse, so clamp to 2.
    always_comb begin
        eff         = (sh_int_reg < INT_W'(2)) ? (INT_W+1)'(2) : {1'b0, sh_int_reg};
        period_last = eff + {{INT_W{1'b0}}, ext_reg} - (INT_W+1)'(1);
        acc_sum     = {1'b0, acc_reg} + {1'b0, sh_frac_reg};
    end

    assign restart  = enable & sync;
    assign os_tick  = enable & ~sync & ({1'b0, cnt_reg} == period_last);
    assign mid_tick = os_tick & (osc == OSC_W'(OSR / 2 - 1));
    assign bit_tick = osc_wrap;
    assign div_err  = (div_int < INT_W'(2));

    // Shadow divisors only change at period boundaries, so a live divisor
    // update never disturbs the period already in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg     <= '0;
            acc_reg     <= '0;
            ext_reg     <= 1'b0;
            sh_int_reg  <= INT_W'(DEF_INT);
            sh_frac_reg <= '0;
        end else if (restart) begin
            cnt_reg     <= '0;
            acc_reg     <= '0;
            ext_reg     <= 1'b0;
            sh_int_reg  <= div_int;
            sh_frac_reg <= div_frac;
        end else if (os_tick) begin
            cnt_reg     <= '0;
            acc_reg     <= acc_sum[FRAC_W-1:0];
            ext_reg     <= acc_sum[FRAC_W];
            sh_int_reg  <= div_int;
            sh_frac_reg <= div_frac;
        end else if (enable) begin
            cnt_reg     <= cnt_reg + 1'b1;
        end
    end

    mod_counter #(
        .MODULUS (OSR),
        .W       (OSC_W)
    ) u_osc (
        .clk   (clk),
        .reset (reset),
        .clr   (restart),
        .en    (os_tick),
        .count (osc),
        .wrap  (osc_wrap)
    );

endmodule
